// File: rtl/carry_save_resolver.sv
// Resolves a carry-save pair (sum + 2*carry) into one binary value with a chunked ripple adder.
// Latency: accept edge k, result valid from edge k+N (N = ceil((WIDTH+2)/CHUNK)); out_ready stalls DONE indefinitely, input is refused while busy.
module carry_save_resolver #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] sum_in,
    input  logic [WIDTH-1:0] carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH+1:0] result,
    output logic             busy
);

    localparam int RW = WIDTH + 2;
    localparam int N  = (RW + CHUNK - 1) / CHUNK;
    localparam int PW = N * CHUNK;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        DONE
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [PW-1:0]   a_q;
    logic [PW-1:0]   b_q;
    logic [PW-1:0]   acc_q;
    logic [PW-1:0]   acc_d;
    logic [IW-1:0]   idx_q;
    logic            carry_q;
    logic [CHUNK:0]  chunk_sum;
    logic [RW-1:0]   result_q;
    logic            accept;
    int              off;

    assign accept    = (state_q == IDLE) && in_valid;
    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = ADD;
            ADD:     if (idx_q == LAST) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // One CHUNK-wide slice of the padded operands per ADD cycle, rippling carry_q between slices.
    always_comb begin
        off       = int'(idx_q) * CHUNK;
        acc_d     = acc_q;
        chunk_sum = {1'b0, a_q[off +: CHUNK]} + {1'b0, b_q[off +: CHUNK]}
                  + {{CHUNK{1'b0}}, carry_q};
        acc_d[off +: CHUNK] = chunk_sum[CHUNK-1:0];
    end

    // result_q is only reloaded on the last chunk so it stays stable between operations.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            result_q <= '0;
        end else if (accept) begin
            a_q     <= {{(PW - WIDTH){1'b0}}, sum_in};
            b_q     <= {{(PW - WIDTH - 1){1'b0}}, carry_in, 1'b0};
            acc_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
        end else if (state_q == ADD) begin
            acc_q   <= acc_d;
            carry_q <= chunk_sum[CHUNK];
            idx_q   <= idx_q + IW'(1);
            if (idx_q == LAST) begin
                result_q <= acc_d[RW-1:0];
            end
        end
    end

endmodule

// File: tb/tb_carry_save_resolver.sv
// Directed and random checks of carry_save_resolver against an arithmetic reference (sum + 2*carry).
module tb_carry_save_resolver;

    localparam int WIDTH = 32;
    localparam int CHUNK = 8;
    localparam int N     = (WIDTH + 2 + CHUNK - 1) / CHUNK;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [WIDTH-1:0]  sum_in = '0;
    logic [WIDTH-1:0]  carry_in = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [WIDTH+1:0]  result;
    logic              busy;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int accept_q[$];
    logic [WIDTH+1:0] out_q[$];

    carry_save_resolver #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .sum_in(sum_in), .carry_in(carry_in), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Handshakes seen at the falling edge complete on the following rising edge.
    always @(negedge clk) begin
        if (rst_n && in_valid && in_ready) accept_q.push_back(cyc + 1);
        if (rst_n && out_valid && out_ready) out_q.push_back(result);
    end

    function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] c);
        return {2'b00, s} + ({2'b00, c} << 1);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present an operand pair while idle and step through the accepting edge.
    task automatic start(input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] c);
        chk("idle_in_ready", in_ready, 1);
        sum_in = s; carry_in = c; in_valid = 1'b1;
        @(posedge clk); #1;
        chk("accept_busy", busy, 1);
        chk("accept_in_ready", in_ready, 0);
        in_valid = 1'b0;
        sum_in = $urandom; carry_in = $urandom;
    endtask

    task automatic wait_done(input logic [WIDTH+1:0] exp);
        for (int i = 1; i <= N; i++) begin
            @(posedge clk); #1;
            chk("out_valid_timing", out_valid, (i == N));
        end
        chk("result", result, exp);
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("consume_out_valid", out_valid, 0);
        chk("consume_busy", busy, 0);
        chk("consume_in_ready", in_ready, 1);
    endtask

    initial begin
        logic [WIDTH-1:0] s;
        logic [WIDTH-1:0] c;
        logic [WIDTH+1:0] held;
        int consume_cyc;

        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 1);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic, full carry ripple, maximum operands.
        start(32'h0000_0005, 32'h0000_0003); wait_done(34'h0_0000_000B); consume();
        start(32'hFFFF_FFFF, 32'h0000_0001); wait_done(34'h1_0000_0001); consume();
        start(32'hFFFF_FFFF, 32'hFFFF_FFFF); wait_done(34'h2_FFFF_FFFD); consume();

        // Backpressure in DONE with a competing operand pair offered.
        out_ready = 1'b0;
        start(32'hDEAD_BEEF, 32'h0BAD_F00D);
        wait_done(model(32'hDEAD_BEEF, 32'h0BAD_F00D));
        held = result;
        accept_q.delete();
        sum_in = 32'd7; carry_in = 32'd9; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("bp_out_valid", out_valid, 1);
            chk("bp_result", result, held);
            chk("bp_in_ready", in_ready, 0);
        end
        chk("bp_no_accept", accept_q.size(), 0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        consume_cyc = cyc;
        chk("bp_release_out_valid", out_valid, 0);
        @(posedge clk); #1;
        chk("bp_next_accept_busy", busy, 1);
        in_valid = 1'b0;
        chk("bp_accept_count", accept_q.size(), 1);
        if (accept_q.size() == 1) chk("bp_accept_edge", accept_q[0], consume_cyc + 1);
        wait_done(34'd25);
        consume();

        // Asynchronous reset during the third ADD cycle.
        start(32'hCAFE_0001, 32'h1357_9BDF);
        @(posedge clk); @(posedge clk); #2;
        rst_n = 1'b0; #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_result", result, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_in_ready", in_ready, 1);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        start(32'h1234_5678, 32'h1111_1111); wait_done(34'h0_3456_789A); consume();

        // Back-to-back with in_valid held high.
        accept_q.delete(); out_q.delete();
        sum_in = 32'd1; carry_in = 32'd1; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        sum_in = 32'd2; carry_in = 32'd2;
        repeat (2 * (N + 2) - 1) @(posedge clk);
        #1; in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("b2b_accepts", accept_q.size(), 2);
        chk("b2b_outputs", out_q.size(), 2);
        if (accept_q.size() == 2) chk("b2b_interval", accept_q[1] - accept_q[0], N + 2);
        if (out_q.size() == 2) begin
            chk("b2b_first", out_q[0], 34'h3);
            chk("b2b_second", out_q[1], 34'h6);
        end

        // Random operands with random backpressure in DONE.
        for (int t = 0; t < 25; t++) begin
            s = $urandom; c = $urandom;
            out_ready = 1'b0;
            start(s, c);
            wait_done(model(s, c));
            held = result;
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #1;
                chk("rand_hold_valid", out_valid, 1);
                chk("rand_hold_result", result, held);
            end
            consume();
            chk("rand_result_kept", result, held);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/carry_save_resolver.md
# carry_save_resolver

Sequential resolver that converts a carry-save pair (SUM, CARRY) from the team's 4:2 compressor tree into a single binary result, value = SUM + (CARRY << 1). It sits at the output of the compressor array in the multiplier/accumulator datapath. It replaces a wide single-cycle carry-propagate adder with a chunked ripple adder that processes CHUNK bits per clock. Operands arrive on a valid/ready handshake and the result leaves on another one.

## Interface
- WIDTH, 32: width of the SUM and CARRY operands.
- CHUNK, 8: bits added per ADD cycle; legal range 1..WIDTH+2.
- Derived, not overridable: RW = WIDTH+2 is the result width. N = ceil(RW/CHUNK) is the ADD cycle count (5 for the defaults).
- CLK  in  1  single clock; all state updates on its rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- IN_VALID  in  1  operand pair valid.
- IN_READY  out  1  resolver can accept an operand pair.
- SUM_IN  in  WIDTH  sum vector of the carry-save pair.
- CARRY_IN  in  WIDTH  carry vector, weight 2 relative to SUM_IN (shifted left by 1 internally).
- OUT_VALID  out  1  RESULT valid.
- OUT_READY  in  1  downstream accepts RESULT.
- RESULT  out  RW  binary value SUM_IN + 2*CARRY_IN.
- BUSY  out  1  high in ADD or DONE.

## Operation
- State machine has three states: IDLE, ADD and DONE. Reset state is IDLE.
- IDLE:
  - IN_READY=1.
  - On IN_VALID & IN_READY, latch A = zero-extended SUM_IN and B = zero-extended {CARRY_IN,1'b0}, both padded to N*CHUNK bits.
  - Clear the chunk index and the carry register, then go to ADD.
- ADD:
  - Each cycle, add chunk i of A, chunk i of B and the carry register.
  - Write the CHUNK-bit sum into chunk i of the result register and store the carry-out in the carry register.
  - Increment i. After chunk N-1, go to DONE.
- DONE:
  - OUT_VALID=1 and RESULT = the low RW bits of the result register.
  - On OUT_READY, go to IDLE.
- Arithmetic:
  - Unsigned. The maximum value 3*(2^WIDTH-1) always fits in RW bits.
  - The final carry-out from the padded chunk is always 0 and is discarded.
- Register the operands at acceptance. SUM_IN and CARRY_IN may change freely after the handshake.
- IN_READY=0 in ADD and DONE. IN_VALID in those states is ignored and nothing is latched.
- IN_READY is decoded from state. There is no input-to-output combinational path except through registered state.
- OUT_READY outside DONE is ignored.
- Reset (RST_N low) at any time, including mid-ADD or in DONE, takes effect immediately:
  - state=IDLE;
  - OUT_VALID=0, RESULT=0, BUSY=0;
  - carry register and chunk index = 0;
  - IN_READY=1.
  - The in-flight operation is lost.

## Timing
- Reset values: OUT_VALID=0, RESULT=0, BUSY=0, IN_READY=1.
- Acceptance edge k: BUSY=1 and IN_READY=0 from edge k.
- ADD occupies edges k+1 .. k+N.
- OUT_VALID rises at edge k+N. RESULT is valid and stable from that edge until the consuming edge.
- Consuming edge m (OUT_VALID & OUT_READY): OUT_VALID=0, BUSY=0 and IN_READY=1 from edge m. The earliest next accept is edge m+1.
- With OUT_READY tied high, the accept-to-accept interval is N+2 cycles (7 for the defaults).
- RESULT holds its last value after consumption until the next DONE; only OUT_VALID qualifies it.
- Backpressure of any length in DONE keeps RESULT and OUT_VALID constant.

## Test plan
- Basic sum: SUM_IN=0x00000005, CARRY_IN=0x00000003, OUT_READY=1 -> RESULT=0x0000000B with OUT_VALID rising exactly 5 cycles after the accept edge.
- Carry ripple across all chunks: SUM_IN=0xFFFFFFFF, CARRY_IN=0x00000001 -> RESULT=0x100000001.
- Maximum operands: SUM_IN=0xFFFFFFFF, CARRY_IN=0xFFFFFFFF -> RESULT=0x2FFFFFFFD, with no wrap in the 34-bit output.
- Backpressure:
  - Stimulus: OUT_READY=0 for 10 cycles in DONE while IN_VALID=1 with new operands.
  - Response: RESULT and OUT_VALID stay constant, IN_READY=0 and no new operand is latched.
  - When OUT_READY is released, consumption happens in 1 cycle and the new operand is accepted on the next edge.
- Reset mid-operation:
  - Stimulus: RST_N low during the 3rd ADD cycle.
  - Response: OUT_VALID=0, RESULT=0, BUSY=0 and IN_READY=1 asynchronously.
  - After release, SUM_IN=0x12345678, CARRY_IN=0x11111111 -> RESULT=0x3456789A.
- Back-to-back: IN_VALID held high with two pairs (1,1) then (2,2) and OUT_READY=1 -> RESULT=0x3 then 0x6, with accept edges 7 cycles apart.
